// File: rtl/decode_pkg.sv
// ---------------------------------------------------------------------------
// decode_pkg
// Shared types and constants for the RV32I decode stage.
//   - OPC_*            : major opcode encodings (inst[6:0])
//   - opcode_class_e   : instruction class derived from the opcode
//   - imm_fmt_e        : immediate layout selector for imm_gen
//   - decoded_bundle_t : registered control flags of a decoded instruction
//   - classify()       : opcode -> opcode_class_e
// ---------------------------------------------------------------------------
package decode_pkg;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_L     = 7'b0000011;
    localparam logic [6:0] OPC_S     = 7'b0100011;
    localparam logic [6:0] OPC_B     = 7'b1100011;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    typedef enum logic [3:0] {
        CLS_R,
        CLS_I,
        CLS_L,
        CLS_S,
        CLS_B,
        CLS_JALR,
        CLS_JAL,
        CLS_LUI,
        CLS_AUIPC,
        CLS_ILLEGAL
    } opcode_class_e;

    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } imm_fmt_e;

    typedef struct packed {
        logic alu_src;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jump;
        logic illegal;
    } decoded_bundle_t;

    function automatic opcode_class_e classify(input logic [6:0] opc);
        opcode_class_e cls;
        case (opc)
            OPC_R:     cls = CLS_R;
            OPC_I:     cls = CLS_I;
            OPC_L:     cls = CLS_L;
            OPC_S:     cls = CLS_S;
            OPC_B:     cls = CLS_B;
            OPC_JALR:  cls = CLS_JALR;
            OPC_JAL:   cls = CLS_JAL;
            OPC_LUI:   cls = CLS_LUI;
            OPC_AUIPC: cls = CLS_AUIPC;
            default:   cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// ---------------------------------------------------------------------------
// imm_gen
// Purely combinational immediate generator. Assembles the immediate for the
// selected RV32I format and sign-extends it from inst[31] to XLEN.
//   inst_hi : instruction bits [31:7] (the opcode never feeds an immediate)
//   fmt     : immediate format; FMT_NONE yields zero
//   imm     : XLEN-wide sign-extended immediate
// ---------------------------------------------------------------------------
module imm_gen
    import decode_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:7]     inst_hi,
    input  imm_fmt_e        fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (fmt)
            FMT_I: imm32 = {{20{inst_hi[31]}}, inst_hi[31:20]};
            FMT_S: imm32 = {{20{inst_hi[31]}}, inst_hi[31:25], inst_hi[11:7]};
            FMT_B: imm32 = {{19{inst_hi[31]}}, inst_hi[31], inst_hi[7],
                            inst_hi[30:25], inst_hi[11:8], 1'b0};
            FMT_U: imm32 = {inst_hi[31:12], 12'b0};
            FMT_J: imm32 = {{11{inst_hi[31]}}, inst_hi[31], inst_hi[19:12],
                            inst_hi[20], inst_hi[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        // Every format is already sign-extended to 32 bits; widen to XLEN.
        imm = XLEN'($signed(imm32));
    end

endmodule

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
// Registered RV32I decode stage with valid/ready handshake on both sides and
// a pipeline flush. One cycle from accepted instruction to out_valid.
//   clk, n_rst            : clock, asynchronous active-low reset
//   in_valid/in_ready     : upstream handshake, instruction word
//   flush                 : drops the held bundle and any incoming word
//   out_valid/out_ready   : downstream handshake
//   rd, rs1, rs2, imm     : decoded register indices and immediate
//   alu_src .. illegal    : decoded control flags
// Optional build macro DECODE_PERF_CNT_EN adds saturating counters
//   decoded_cnt (output transfers) and illegal_cnt (illegal output transfers).
// ---------------------------------------------------------------------------
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned REG_W = 5
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [REG_W-1:0] rd,
    output logic [REG_W-1:0] rs1,
    output logic [REG_W-1:0] rs2,
    output logic [XLEN-1:0]  imm,
    output logic             alu_src,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             branch,
    output logic             jump,
    output logic             illegal
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0]      decoded_cnt,
    output logic [31:0]      illegal_cnt
`endif
);

    // ---------------- combinational decode ----------------
    opcode_class_e   cls;
    imm_fmt_e        fmt;
    decoded_bundle_t dec;
    logic            use_rd, use_rs1, use_rs2;
    logic [REG_W-1:0] dec_rd, dec_rs1, dec_rs2;
    logic [XLEN-1:0] dec_imm;

    always_comb begin
        cls     = classify(instruction[6:0]);
        fmt     = FMT_NONE;
        dec     = '0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (cls)
            CLS_R: begin
                dec.reg_write = 1'b1;
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            CLS_I: begin
                fmt = FMT_I;
                dec.alu_src = 1'b1; dec.reg_write = 1'b1;
                use_rd = 1'b1; use_rs1 = 1'b1;
            end
            CLS_L: begin
                fmt = FMT_I;
                dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.mem_read = 1'b1;
                use_rd = 1'b1; use_rs1 = 1'b1;
            end
            CLS_S: begin
                fmt = FMT_S;
                dec.alu_src = 1'b1; dec.mem_write = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            CLS_B: begin
                fmt = FMT_B;
                dec.branch = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            CLS_JALR: begin
                fmt = FMT_I;
                dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.jump = 1'b1;
                use_rd = 1'b1; use_rs1 = 1'b1;
            end
            CLS_JAL: begin
                fmt = FMT_J;
                dec.reg_write = 1'b1; dec.jump = 1'b1;
                use_rd = 1'b1;
            end
            CLS_LUI, CLS_AUIPC: begin
                fmt = FMT_U;
                dec.alu_src = 1'b1; dec.reg_write = 1'b1;
                use_rd = 1'b1;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase

        dec_rd  = use_rd  ? REG_W'(instruction[11:7])  : '0;
        dec_rs1 = use_rs1 ? REG_W'(instruction[19:15]) : '0;
        dec_rs2 = use_rs2 ? REG_W'(instruction[24:20]) : '0;

        // Writes to x0 are architecturally discarded; suppress them here.
        if (dec_rd == '0) begin
            dec.reg_write = 1'b0;
        end
    end

    imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .inst_hi (instruction[31:7]),
        .fmt     (fmt),
        .imm     (dec_imm)
    );

    // ---------------- pipeline register ----------------
    logic             out_valid_q, out_valid_d;
    logic [REG_W-1:0] rd_q, rd_d;
    logic [REG_W-1:0] rs1_q, rs1_d;
    logic [REG_W-1:0] rs2_q, rs2_d;
    logic [XLEN-1:0]  imm_q, imm_d;
    decoded_bundle_t  ctrl_q, ctrl_d;
    logic             load;
    logic             out_fire;

    assign in_ready = !out_valid_q || out_ready;
    assign load     = in_valid && in_ready && !flush;
    assign out_fire = out_valid_q && out_ready && !flush;

    always_comb begin
        rd_d   = rd_q;
        rs1_d  = rs1_q;
        rs2_d  = rs2_q;
        imm_d  = imm_q;
        ctrl_d = ctrl_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (load) begin
            out_valid_d = 1'b1;
        end else begin
            out_valid_d = out_valid_q && !out_ready;
        end
        if (load) begin
            rd_d   = dec_rd;
            rs1_d  = dec_rs1;
            rs2_d  = dec_rs2;
            imm_d  = dec_imm;
            ctrl_d = dec;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            out_valid_q <= 1'b0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            imm_q       <= '0;
            ctrl_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            rd_q        <= rd_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            imm_q       <= imm_d;
            ctrl_q      <= ctrl_d;
        end
    end

    assign out_valid = out_valid_q;
    assign rd        = rd_q;
    assign rs1       = rs1_q;
    assign rs2       = rs2_q;
    assign imm       = imm_q;
    assign alu_src   = ctrl_q.alu_src;
    assign reg_write = ctrl_q.reg_write;
    assign mem_read  = ctrl_q.mem_read;
    assign mem_write = ctrl_q.mem_write;
    assign branch    = ctrl_q.branch;
    assign jump      = ctrl_q.jump;
    assign illegal   = ctrl_q.illegal;

`ifdef DECODE_PERF_CNT_EN
    // ---------------- saturating performance counters ----------------
    logic [31:0] decoded_cnt_q, decoded_cnt_d;
    logic [31:0] illegal_cnt_q, illegal_cnt_d;

    always_comb begin
        decoded_cnt_d = decoded_cnt_q;
        illegal_cnt_d = illegal_cnt_q;
        if (out_fire && (decoded_cnt_q != '1)) begin
            decoded_cnt_d = decoded_cnt_q + 32'd1;
        end
        if (out_fire && ctrl_q.illegal && (illegal_cnt_q != '1)) begin
            illegal_cnt_d = illegal_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            decoded_cnt_q <= '0;
            illegal_cnt_q <= '0;
        end else begin
            decoded_cnt_q <= decoded_cnt_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign decoded_cnt = decoded_cnt_q;
    assign illegal_cnt = illegal_cnt_q;
`else
    logic unused_out_fire;
    assign unused_out_fire = out_fire;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
// Directed bench for decode_stage. Expected bundles are produced by a
// reference decoder when an instruction is accepted and queued; they are
// compared against the DUT outputs every cycle the bundle is valid.
// ---------------------------------------------------------------------------
module tb_decode_stage;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        alu_src;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        alu_src, reg_write, mem_read, mem_write, branch, jump, illegal;
`ifdef DECODE_PERF_CNT_EN
    logic [31:0] decoded_cnt, illegal_cnt;
    int unsigned exp_dec = 0;
    int unsigned exp_ill = 0;
`endif

    exp_t obs;
    exp_t sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    decode_stage #(
        .XLEN  (32),
        .REG_W (5)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instruction (instruction),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .imm         (imm),
        .alu_src     (alu_src),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .branch      (branch),
        .jump        (jump),
        .illegal     (illegal)
`ifdef DECODE_PERF_CNT_EN
        ,
        .decoded_cnt (decoded_cnt),
        .illegal_cnt (illegal_cnt)
`endif
    );

    always_comb obs = {rd, rs1, rs2, imm, alu_src, reg_write, mem_read,
                       mem_write, branch, jump, illegal};

    function automatic exp_t model(input logic [31:0] i);
        exp_t e;
        e = '0;
        case (i[6:0])
            7'h33: begin e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
                         e.reg_write = 1'b1; end
            7'h13: begin e.rd = i[11:7]; e.rs1 = i[19:15];
                         e.imm = {{20{i[31]}}, i[31:20]};
                         e.alu_src = 1'b1; e.reg_write = 1'b1; end
            7'h03: begin e.rd = i[11:7]; e.rs1 = i[19:15];
                         e.imm = {{20{i[31]}}, i[31:20]};
                         e.alu_src = 1'b1; e.reg_write = 1'b1; e.mem_read = 1'b1; end
            7'h23: begin e.rs1 = i[19:15]; e.rs2 = i[24:20];
                         e.imm = {{20{i[31]}}, i[31:25], i[11:7]};
                         e.alu_src = 1'b1; e.mem_write = 1'b1; end
            7'h63: begin e.rs1 = i[19:15]; e.rs2 = i[24:20];
                         e.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
                         e.branch = 1'b1; end
            7'h67: begin e.rd = i[11:7]; e.rs1 = i[19:15];
                         e.imm = {{20{i[31]}}, i[31:20]};
                         e.alu_src = 1'b1; e.reg_write = 1'b1; e.jump = 1'b1; end
            7'h6F: begin e.rd = i[11:7];
                         e.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
                         e.reg_write = 1'b1; e.jump = 1'b1; end
            7'h37, 7'h17: begin e.rd = i[11:7]; e.imm = {i[31:12], 12'h000};
                         e.alu_src = 1'b1; e.reg_write = 1'b1; end
            default: e.illegal = 1'b1;
        endcase
        if (e.rd == 5'd0) e.reg_write = 1'b0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] x);
        n_cmp++;
        assert (o === x) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, o, x);
        end
    endtask

    // One clock of stimulus: drive at the falling edge, check shortly after,
    // update the scoreboard for the transfers the coming rising edge performs.
    task automatic step(input logic iv, input logic [31:0] ins,
                        input logic ordy, input logic fl);
        logic exp_valid;
        in_valid = iv; instruction = ins; out_ready = ordy; flush = fl;
        #1;
        exp_valid = (sb.size() != 0);
        chk("out_valid", 64'(out_valid), 64'(exp_valid));
        chk("in_ready", 64'(in_ready), 64'(!exp_valid || ordy));
        if (exp_valid) chk("bundle", 64'(obs), 64'(sb[0]));
        if (exp_valid && ordy && !fl) begin
`ifdef DECODE_PERF_CNT_EN
            exp_dec++;
            if (sb[0].illegal) exp_ill++;
`endif
            void'(sb.pop_front());
        end
        if (fl) sb.delete();
        else if (iv && (!exp_valid || ordy)) sb.push_back(model(ins));
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_rst = 1'b0; in_valid = 1'b0; instruction = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_bundle", 64'(obs), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        n_rst = 1'b1;

        // addi x5,x6,-1
        step(1'b1, 32'hFFF30293, 1'b1, 1'b0);
        chk("addi_valid", 64'(out_valid), 64'd1);
        chk("addi_rd", 64'(rd), 64'd5);
        chk("addi_rs1", 64'(rs1), 64'd6);
        chk("addi_rs2", 64'(rs2), 64'd0);
        chk("addi_imm", 64'(imm), 64'hFFFFFFFF);
        chk("addi_flags", 64'({alu_src, reg_write}), 64'b11);
        // sw x7,8(x2)
        step(1'b1, 32'h00712423, 1'b1, 1'b0);
        chk("sw_regs", 64'({rd, rs1, rs2}), 64'({5'd0, 5'd2, 5'd7}));
        chk("sw_imm", 64'(imm), 64'd8);
        chk("sw_flags", 64'({mem_write, reg_write}), 64'b10);
        // beq x0,x0,-4
        step(1'b1, 32'hFE000EE3, 1'b1, 1'b0);
        chk("beq_imm", 64'(imm), 64'hFFFFFFFC);
        chk("beq_flags", 64'({branch, alu_src, rd}), 64'({1'b1, 1'b0, 5'd0}));
        // B-type with inst[7]=0: imm bit 11 clear
        step(1'b1, 32'hFE000E63, 1'b1, 1'b0);
        chk("beq_b7_imm", 64'(imm), 64'hFFFFF7FC);
        // lui x1,0x12345
        step(1'b1, 32'h123450B7, 1'b1, 1'b0);
        chk("lui_imm", 64'(imm), 64'h12345000);
        chk("lui_rs1", 64'(rs1), 64'd0);
        chk("lui_rd_wr", 64'({rd, reg_write}), 64'({5'd1, 1'b1}));
        step(1'b0, '0, 1'b1, 1'b0);

        // backpressure: held bundle stays stable, in_ready low
        step(1'b1, 32'h00A00093, 1'b1, 1'b0);
        repeat (3) step(1'b1, 32'h0000A183, 1'b0, 1'b0);
        // continuous stream at full throughput
        step(1'b1, 32'h0000A183, 1'b1, 1'b0);
        step(1'b1, 32'h002081B3, 1'b1, 1'b0);
        step(1'b1, 32'h00000033, 1'b1, 1'b0);
        step(1'b1, 32'h008000EF, 1'b1, 1'b0);
        step(1'b1, 32'h000080E7, 1'b1, 1'b0);
        step(1'b1, 32'h00001517, 1'b1, 1'b0);
        step(1'b1, 32'hFFFFF06F, 1'b1, 1'b0);
        step(1'b1, 32'h0000007F, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // flush with a held bundle and an incoming word in the same cycle
        step(1'b1, 32'h00100113, 1'b1, 1'b0);
        step(1'b1, 32'h00200193, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // all-zero word is illegal
        step(1'b1, 32'h00000000, 1'b1, 1'b0);
        chk("illegal_bundle", 64'(obs), 64'd1);
        step(1'b0, '0, 1'b1, 1'b0);
`ifdef DECODE_PERF_CNT_EN
        chk("decoded_cnt", 64'(decoded_cnt), 64'(exp_dec));
        chk("illegal_cnt", 64'(illegal_cnt), 64'(exp_ill));
`endif

        // reset while a bundle is held under backpressure
        step(1'b1, 32'h00A00093, 1'b1, 1'b0);
        step(1'b1, 32'h0000A183, 1'b0, 1'b0);
        in_valid = 1'b0; out_ready = 1'b0;
        #2 n_rst = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_bundle", 64'(obs), 64'd0);
        sb.delete();
`ifdef DECODE_PERF_CNT_EN
        chk("rst_mid_cnt", 64'({decoded_cnt, illegal_cnt}), 64'd0);
        exp_dec = 0; exp_ill = 0;
`endif
        @(negedge clk);
        n_rst = 1'b1;
        step(1'b1, 32'h00712423, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
